acpu_mem_gen: RTL and testbench
===============================

Name: acpu_mem_gen

Overview:
Parametrised audio-CPU memory subsystem for the sound board; it replaces the single-register sound-latch memory map.
- Decodes the audio CPU address bus into ROM, work RAM, two FM chip selects and a command port.
- Holds the download-loaded sound ROM and the work RAM.
- Adds a main-to-sound command FIFO with IRQ/NMI generation, a sound-to-main reply latch with handshake, and a sticky overflow flag.

Parameters:
RAM_AW, 11, work RAM address width (RAM mirrored through the whole 8 KB region)
ROM_AW, 15, ROM address width (ROM mirrored in 0x8000-0xFFFF)
ROM_BASE, 27'hC000, ioctl byte address of ROM byte 0 during download
FIFO_DEPTH, 2, command FIFO entries (power of two, 1..16)
IRQ_MODE, 0, 0 = level IRQ while FIFO non-empty; 1 = NMI pulse per push
NMI_LEN, 16, pulse length in clk_sys cycles when IRQ_MODE=1
EXT_ROM, 0, 1 = ROM data taken from rom_data, internal ROM not built

Ports:
clk_sys in 1 system clock
reset in 1 asynchronous active-high reset
cpu_cen in 1 audio CPU clock enable; one bus access per enabled cycle
acpu_ab in 16 audio CPU address
din in 8 audio CPU write data
dout out 8 audio CPU read data
rw in 1 1 = read, 0 = write
ioctl_download in 1 ROM download active
ioctl_addr in 27 download byte address
ioctl_dout in 16 download data; bits 7:0 used
ioctl_wr in 1 download write strobe
mcpu_dout in 8 main CPU command byte
snd_write in 1 one-cycle push strobe from main CPU
mcpu_reply out 8 reply byte for main CPU
reply_valid out 1 reply unread
reply_ack in 1 one-cycle main CPU reply read
cs1 out 1 YM2203 select
cs2 out 1 YM3526 select
ym2203_data in 8 YM2203 read data
ym3526_data in 8 YM3526 read data
rom_cs out 1 ROM region select
rom_addr out ROM_AW ROM address
rom_data in 8 external ROM data
snd_irq out 1 interrupt to audio CPU
fifo_count out 5 current FIFO occupancy
overflow out 1 sticky: push lost because FIFO full

Behaviour:
Clocking and reset
- One clock domain, clk_sys. reset is asynchronous and active-high.
- On reset: FIFO empty, fifo_count=0, snd_irq=0, overflow=0, mcpu_reply=0, reply_valid=0, NMI counter=0, last-read register=8'hFF.
- RAM and ROM contents are not reset.

Address decode (combinational)
- A15=1: rom_cs=1, rom_addr=acpu_ab[ROM_AW-1:0].
- A15=0: region selected by A14:13: 0 = RAM, 1 = cs1, 2 = cs2, 3 = command port.
- cs1 and cs2 are unqualified by cpu_cen.

dout mux (combinational)
- Sources: RAM q, ym2203_data, ym3526_data, FIFO head (or last-read register when FIFO empty), ROM q.
- RAM and ROM are synchronous-read and must be registered by the next cpu_cen.

RAM
- Written when cpu_cen=1, rw=0 and region 0, using acpu_ab[RAM_AW-1:0].

ROM download
- Internal ROM written with ioctl_dout[7:0] at address ioctl_addr-ROM_BASE when ioctl_download=1, ioctl_wr=1 and ROM_BASE <= ioctl_addr < ROM_BASE+2^ROM_AW.
- Writes outside that window are ignored.

Command FIFO
- Push: snd_write=1 pushes mcpu_dout.
- Pop: cpu_cen=1, rw=1 and region 3 pops the head. On the same edge the popped value is copied into the last-read register.
- Push while full: data dropped, overflow set to 1 (sticky until reset). FIFO contents unchanged.
- Pop while empty: no state change; dout returns the last-read register.
- Simultaneous push and pop: both take effect, count unchanged. Pop on full plus push is accepted without overflow.
- Pointers wrap modulo FIFO_DEPTH.
- fifo_count is updated on the edge of the push or pop.

Reply latch
- cpu_cen=1, rw=0 and region 3: mcpu_reply<=din, reply_valid<=1.
- reply_ack clears reply_valid; mcpu_reply holds its value.
- Write and ack in the same cycle: write wins, reply_valid=1.

Interrupt
- IRQ_MODE=0: snd_irq is registered (fifo_count!=0), so it follows the count with one cycle of latency.
- IRQ_MODE=1: each accepted push loads the NMI counter with NMI_LEN. snd_irq=1 while counter!=0; counter decrements each cycle.
- IRQ_MODE=1, push during an active pulse: counter reloads (pulse retriggered). Dropped pushes do not trigger a pulse.

Download interaction
- ioctl_download does not block CPU decode. The top level holds the audio CPU in reset during download.

Test Plan:
- Reset, then read 0x6000 with FIFO empty -> dout=8'hFF, snd_irq=0, fifo_count=0.
- IRQ_MODE=0: push 0x12, 0x34; read 0x6000 twice -> dout 0x12 then 0x34, fifo_count 2->1->0, snd_irq drops one cycle after count reaches 0.
- FIFO_DEPTH=2: push 0xA1, 0xA2, 0xA3 -> overflow=1, reads return 0xA1, 0xA2; a third read returns 0xA2 (last-read).
- Full FIFO, same-cycle push 0x55 and pop -> no overflow, count stays 2, next reads return second entry then 0x55.
- IRQ_MODE=1, NMI_LEN=16: push, then push again 5 cycles later -> snd_irq high for 21 continuous cycles.
- Download bytes 0xDE, 0xAD at ioctl_addr 0xC000, 0xC001, and 0x77 at 0x14000 -> CPU reads 0x8000=0xDE, 0x8001=0xAD, 0x14000 write ignored; audio write 0x9C to 0x7FFF -> reply_valid=1, mcpu_reply=0x9C, reply_ack clears reply_valid.

Source files
------------

// File: rtl/acpu_mem_gen.sv
// Audio-CPU memory subsystem: address decode, download-loaded ROM, work RAM,
// main-to-sound command FIFO with IRQ/NMI, sound-to-main reply latch.
module acpu_mem_gen #(
    parameter int          RAM_AW     = 11,
    parameter int          ROM_AW     = 15,
    parameter logic [26:0] ROM_BASE   = 27'hC000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          IRQ_MODE   = 0,
    parameter int          NMI_LEN    = 16,
    parameter int          EXT_ROM    = 0
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              cpu_cen,
    input  logic [15:0]       acpu_ab,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    input  logic              rw,
    input  logic              ioctl_download,
    input  logic [26:0]       ioctl_addr,
    input  logic [15:0]       ioctl_dout,
    input  logic              ioctl_wr,
    input  logic [7:0]        mcpu_dout,
    input  logic              snd_write,
    output logic [7:0]        mcpu_reply,
    output logic              reply_valid,
    input  logic              reply_ack,
    output logic              cs1,
    output logic              cs2,
    input  logic [7:0]        ym2203_data,
    input  logic [7:0]        ym3526_data,
    output logic              rom_cs,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              snd_irq,
    output logic [4:0]        fifo_count,
    output logic              overflow
);

    localparam int         PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int         NW      = $clog2(NMI_LEN + 1);
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);
    localparam logic [27:0] ROM_END = {1'b0, ROM_BASE} + (28'd1 << ROM_AW);

    // Address decode
    logic [1:0] region;
    logic       sel_ram;
    logic       sel_cmd;

    assign region   = acpu_ab[14:13];
    assign sel_ram  = !acpu_ab[15] && (region == 2'd0);
    assign sel_cmd  = !acpu_ab[15] && (region == 2'd3);
    assign cs1      = !acpu_ab[15] && (region == 2'd1);
    assign cs2      = !acpu_ab[15] && (region == 2'd2);
    assign rom_cs   = acpu_ab[15];
    assign rom_addr = acpu_ab[ROM_AW-1:0];

    // Some download/ROM inputs are only consumed by one of the ROM variants.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, ioctl_dout, ioctl_addr, ioctl_wr, ioctl_download, rom_data};

    // Work RAM, mirrored through the 8 KB region
    logic [7:0] ram_mem [0:(1<<RAM_AW)-1];
    logic [7:0] ram_q;
    logic       ram_we;

    assign ram_we = cpu_cen && !rw && sel_ram;

    always_ff @(posedge clk_sys) begin
        if (ram_we)
            ram_mem[acpu_ab[RAM_AW-1:0]] <= din;
        ram_q <= ram_mem[acpu_ab[RAM_AW-1:0]];
    end

    // Sound ROM
    logic [7:0] rom_rd;

    generate
        if (EXT_ROM == 0) begin : g_int_rom
            logic [7:0]        rom_mem [0:(1<<ROM_AW)-1];
            logic [7:0]        rom_q;
            logic [ROM_AW-1:0] dl_off;
            logic              dl_hit;

            // Low bits of a modular subtraction are exact, so only ROM_AW bits are needed.
            assign dl_off = ioctl_addr[ROM_AW-1:0] - ROM_BASE[ROM_AW-1:0];
            assign dl_hit = ioctl_download && ioctl_wr &&
                            ({1'b0, ioctl_addr} >= {1'b0, ROM_BASE}) &&
                            ({1'b0, ioctl_addr} < ROM_END);

            always_ff @(posedge clk_sys) begin
                if (dl_hit)
                    rom_mem[dl_off] <= ioctl_dout[7:0];
                rom_q <= rom_mem[acpu_ab[ROM_AW-1:0]];
            end

            assign rom_rd = rom_q;
        end else begin : g_ext_rom
            assign rom_rd = rom_data;
        end
    endgenerate

    // Command FIFO and reply latch state
    logic [7:0]    fifo_mem [0:FIFO_DEPTH-1];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    logic [7:0]    last_q, last_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    reply_q, reply_d;
    logic          reply_valid_q, reply_valid_d;
    logic          pop;
    logic          push;
    logic          full;
    logic          reply_we;
    logic [7:0]    head;
    logic [7:0]    cmd_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (FIFO_DEPTH == 1)
            ptr_inc = '0;
        else
            ptr_inc = p + 1'b1;
    endfunction

    assign head     = fifo_mem[rd_ptr_q];
    assign full     = (count_q == DEPTH_C);
    assign pop      = cpu_cen && rw && sel_cmd && (count_q != 5'd0);
    // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted.
    assign push     = snd_write && (!full || pop);
    assign reply_we = cpu_cen && !rw && sel_cmd;
    assign cmd_data = (count_q != 5'd0) ? head : last_q;

    always_ff @(posedge clk_sys) begin
        if (push)
            fifo_mem[wr_ptr_q] <= mcpu_dout;
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        last_d        = last_q;
        overflow_d    = overflow_q;
        reply_d       = reply_q;
        reply_valid_d = reply_valid_q;

        if (push)
            wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            last_d   = head;
        end
        if (push && !pop)
            count_d = count_q + 5'd1;
        else if (pop && !push)
            count_d = count_q - 5'd1;
        if (snd_write && !push)
            overflow_d = 1'b1;

        if (reply_we) begin
            reply_d       = din;
            reply_valid_d = 1'b1;
        end else if (reply_ack) begin
            reply_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= 5'd0;
            last_q        <= 8'hFF;
            overflow_q    <= 1'b0;
            reply_q       <= 8'h00;
            reply_valid_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            last_q        <= last_d;
            overflow_q    <= overflow_d;
            reply_q       <= reply_d;
            reply_valid_q <= reply_valid_d;
        end
    end

    assign fifo_count  = count_q;
    assign overflow    = overflow_q;
    assign mcpu_reply  = reply_q;
    assign reply_valid = reply_valid_q;

    // Interrupt generation
    generate
        if (IRQ_MODE == 0) begin : g_level_irq
            logic irq_q, irq_d;

            assign irq_d = (count_q != 5'd0);

            always_ff @(posedge clk_sys or posedge reset) begin
                if (reset)
                    irq_q <= 1'b0;
                else
                    irq_q <= irq_d;
            end

            assign snd_irq = irq_q;
        end else begin : g_nmi_pulse
            logic [NW-1:0] nmi_q, nmi_d;

            // Every accepted push retriggers the full pulse length.
            always_comb begin
                nmi_d = nmi_q;
                if (push)
                    nmi_d = NW'(NMI_LEN);
                else if (nmi_q != '0)
                    nmi_d = nmi_q - 1'b1;
            end

            always_ff @(posedge clk_sys or posedge reset) begin
                if (reset)
                    nmi_q <= '0;
                else
                    nmi_q <= nmi_d;
            end

            assign snd_irq = (nmi_q != '0);
        end
    endgenerate

    // CPU read data
    always_comb begin
        dout = 8'hFF;
        if (acpu_ab[15]) begin
            dout = rom_rd;
        end else begin
            case (region)
                2'd0:    dout = ram_q;
                2'd1:    dout = ym2203_data;
                2'd2:    dout = ym3526_data;
                default: dout = cmd_data;
            endcase
        end
    end

endmodule

// File: tb/tb_acpu_mem_gen.sv
// Bench for acpu_mem_gen: level-IRQ/internal-ROM instance plus an
// NMI-mode/external-ROM instance sharing the same stimulus.
module tb_acpu_mem_gen;

    logic        clk_sys;
    logic        reset;
    logic        cpu_cen;
    logic [15:0] acpu_ab;
    logic [7:0]  din;
    logic        rw;
    logic        ioctl_download;
    logic [26:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic        ioctl_wr;
    logic [7:0]  mcpu_dout;
    logic        snd_write;
    logic        reply_ack;
    logic [7:0]  ym2203_data;
    logic [7:0]  ym3526_data;
    logic [7:0]  rom_data_tb;

    logic [7:0]  dout0, dout1, mcpu_reply0, mcpu_reply1;
    logic        reply_valid0, reply_valid1, cs1_0, cs1_1, cs2_0, cs2_1;
    logic        rom_cs0, rom_cs1, snd_irq0, snd_irq1, overflow0, overflow1;
    logic [14:0] rom_addr0, rom_addr1;
    logic [4:0]  fifo_count0, fifo_count1;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q [$];

    // External ROM model for the EXT_ROM instance
    assign rom_data_tb = rom_addr1[7:0] ^ 8'h3C;

    acpu_mem_gen u_dut0 (
        .clk_sys(clk_sys), .reset(reset), .cpu_cen(cpu_cen), .acpu_ab(acpu_ab),
        .din(din), .dout(dout0), .rw(rw), .ioctl_download(ioctl_download),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
        .mcpu_dout(mcpu_dout), .snd_write(snd_write), .mcpu_reply(mcpu_reply0),
        .reply_valid(reply_valid0), .reply_ack(reply_ack), .cs1(cs1_0), .cs2(cs2_0),
        .ym2203_data(ym2203_data), .ym3526_data(ym3526_data), .rom_cs(rom_cs0),
        .rom_addr(rom_addr0), .rom_data(rom_data_tb), .snd_irq(snd_irq0),
        .fifo_count(fifo_count0), .overflow(overflow0)
    );

    acpu_mem_gen #(.IRQ_MODE(1), .NMI_LEN(16), .EXT_ROM(1)) u_dut1 (
        .clk_sys(clk_sys), .reset(reset), .cpu_cen(cpu_cen), .acpu_ab(acpu_ab),
        .din(din), .dout(dout1), .rw(rw), .ioctl_download(ioctl_download),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
        .mcpu_dout(mcpu_dout), .snd_write(snd_write), .mcpu_reply(mcpu_reply1),
        .reply_valid(reply_valid1), .reply_ack(reply_ack), .cs1(cs1_1), .cs2(cs2_1),
        .ym2203_data(ym2203_data), .ym3526_data(ym3526_data), .rom_cs(rom_cs1),
        .rom_addr(rom_addr1), .rom_data(rom_data_tb), .snd_irq(snd_irq1),
        .fifo_count(fifo_count1), .overflow(overflow1)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    typedef enum logic [1:0] {OP_IDLE, OP_PUSH, OP_READ, OP_PUSHPOP} op_e;

    typedef struct packed {
        op_e         op;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp_dout;
        logic [4:0]  exp_cnt;
        logic        exp_irq;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    // One bus cycle: drive at negedge, compare combinational dout, let the edge commit.
    task automatic step(input logic cen, input logic rwi, input logic [15:0] ab,
                        input logic [7:0] d, input logic sw, input logic [7:0] md,
                        input logic ack, input logic chk, input logic [7:0] exp,
                        input string nm);
        logic [7:0] e;
        @(negedge clk_sys);
        cpu_cen = cen; rw = rwi; acpu_ab = ab; din = d;
        snd_write = sw; mcpu_dout = md; reply_ack = ack;
        if (chk) exp_q.push_back(exp);
        #1;
        if (chk) begin
            e = exp_q.pop_front();
            check(nm, 32'(dout0), 32'(e));
        end
        @(posedge clk_sys);
        #1;
        cpu_cen = 1'b0; snd_write = 1'b0; reply_ack = 1'b0; rw = 1'b1;
    endtask

    // Synchronous-read region: present address one edge ahead of the enabled cycle.
    task automatic mem_read(input logic [15:0] ab, input logic [7:0] exp,
                            input bit sel, input string nm);
        logic [7:0] e;
        @(negedge clk_sys);
        cpu_cen = 1'b0; rw = 1'b1; acpu_ab = ab;
        exp_q.push_back(exp);
        @(negedge clk_sys);
        cpu_cen = 1'b1;
        #1;
        e = exp_q.pop_front();
        check(nm, 32'(sel ? dout1 : dout0), 32'(e));
        @(posedge clk_sys);
        #1;
        cpu_cen = 1'b0;
    endtask

    task automatic dl_write(input logic [26:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        ioctl_download = 1'b1; ioctl_addr = a; ioctl_dout = {8'hEE, d}; ioctl_wr = 1'b1;
        @(posedge clk_sys);
        #1;
        ioctl_wr = 1'b0;
    endtask

    initial begin
        int  high_cnt;
        bit  seen_low;
        bit  regap;

        reset = 1'b1; cpu_cen = 1'b0; acpu_ab = 16'h0000; din = 8'h00; rw = 1'b1;
        ioctl_download = 1'b0; ioctl_addr = '0; ioctl_dout = '0; ioctl_wr = 1'b0;
        mcpu_dout = 8'h00; snd_write = 1'b0; reply_ack = 1'b0;
        ym2203_data = 8'hC1; ym3526_data = 8'hC2;

        vecs[0]  = '{OP_READ,    16'h6000, 8'h00, 8'hFF, 5'd0, 1'b0, 1'b0};
        vecs[1]  = '{OP_PUSH,    16'h0000, 8'h12, 8'h00, 5'd1, 1'b0, 1'b0};
        vecs[2]  = '{OP_PUSH,    16'h0000, 8'h34, 8'h00, 5'd2, 1'b1, 1'b0};
        vecs[3]  = '{OP_READ,    16'h6000, 8'h00, 8'h12, 5'd1, 1'b1, 1'b0};
        vecs[4]  = '{OP_READ,    16'h6000, 8'h00, 8'h34, 5'd0, 1'b1, 1'b0};
        vecs[5]  = '{OP_IDLE,    16'h0000, 8'h00, 8'h00, 5'd0, 1'b0, 1'b0};
        vecs[6]  = '{OP_PUSH,    16'h0000, 8'h11, 8'h00, 5'd1, 1'b0, 1'b0};
        vecs[7]  = '{OP_PUSH,    16'h0000, 8'h22, 8'h00, 5'd2, 1'b1, 1'b0};
        vecs[8]  = '{OP_PUSHPOP, 16'h6000, 8'h55, 8'h11, 5'd2, 1'b1, 1'b0};
        vecs[9]  = '{OP_READ,    16'h6000, 8'h00, 8'h22, 5'd1, 1'b1, 1'b0};
        vecs[10] = '{OP_READ,    16'h6000, 8'h00, 8'h55, 5'd0, 1'b1, 1'b0};
        vecs[11] = '{OP_PUSH,    16'h0000, 8'hA1, 8'h00, 5'd1, 1'b0, 1'b0};
        vecs[12] = '{OP_PUSH,    16'h0000, 8'hA2, 8'h00, 5'd2, 1'b1, 1'b0};
        vecs[13] = '{OP_PUSH,    16'h0000, 8'hA3, 8'h00, 5'd2, 1'b1, 1'b1};
        vecs[14] = '{OP_READ,    16'h7ABC, 8'h00, 8'hA1, 5'd1, 1'b1, 1'b1};
        vecs[15] = '{OP_READ,    16'h6000, 8'h00, 8'hA2, 5'd0, 1'b1, 1'b1};
        vecs[16] = '{OP_READ,    16'h6000, 8'h00, 8'hA2, 5'd0, 1'b0, 1'b1};
        vecs[17] = '{OP_IDLE,    16'h0000, 8'h00, 8'h00, 5'd0, 1'b0, 1'b1};

        repeat (3) @(posedge clk_sys);
        #1;
        check("rst count", 32'(fifo_count0), 32'd0);
        check("rst irq0", 32'(snd_irq0), 32'd0);
        check("rst irq1", 32'(snd_irq1), 32'd0);
        check("rst ovf", 32'(overflow0), 32'd0);
        check("rst reply", 32'(mcpu_reply0), 32'h00);
        check("rst rvalid", 32'(reply_valid0), 32'd0);
        @(negedge clk_sys);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            case (vecs[i].op)
                OP_PUSH:    step(1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, vecs[i].data, 1'b0,
                                 1'b0, 8'h00, "");
                OP_READ:    step(1'b1, 1'b1, vecs[i].addr, 8'h00, 1'b0, 8'h00, 1'b0,
                                 1'b1, vecs[i].exp_dout, $sformatf("v%0d dout", i));
                OP_PUSHPOP: step(1'b1, 1'b1, vecs[i].addr, 8'h00, 1'b1, vecs[i].data, 1'b0,
                                 1'b1, vecs[i].exp_dout, $sformatf("v%0d dout", i));
                default:    step(1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0,
                                 1'b0, 8'h00, "");
            endcase
            check($sformatf("v%0d count", i), 32'(fifo_count0), 32'(vecs[i].exp_cnt));
            check($sformatf("v%0d irq", i), 32'(snd_irq0), 32'(vecs[i].exp_irq));
            check($sformatf("v%0d ovf", i), 32'(overflow0), 32'(vecs[i].exp_ovf));
        end

        // Decode and FM data paths
        @(negedge clk_sys);
        acpu_ab = 16'h2000;
        #1;
        check("dec 2000", 32'({rom_cs0, cs2_0, cs1_0}), 32'b001);
        acpu_ab = 16'h4000;
        #1;
        check("dec 4000", 32'({rom_cs0, cs2_0, cs1_0}), 32'b010);
        acpu_ab = 16'h9234;
        #1;
        check("dec 9234", 32'({rom_cs0, cs2_0, cs1_0}), 32'b100);
        check("rom_addr", 32'(rom_addr0), 32'h1234);
        step(1'b1, 1'b1, 16'h2000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'hC1, "ym2203 rd");
        step(1'b1, 1'b1, 16'h5FFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'hC2, "ym3526 rd");

        // Work RAM with mirroring
        step(1'b1, 1'b0, 16'h0010, 8'h5E, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, "");
        step(1'b1, 1'b0, 16'h0011, 8'h6F, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, "");
        mem_read(16'h1810, 8'h5E, 1'b0, "ram mirror");
        mem_read(16'h0011, 8'h6F, 1'b0, "ram 0011");

        // ROM download including both window edges
        dl_write(27'h0C000, 8'hDE);
        dl_write(27'h0C001, 8'hAD);
        dl_write(27'h13FFF, 8'h44);
        dl_write(27'h14000, 8'h77);
        dl_write(27'h0BFFF, 8'hBB);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        mem_read(16'h8000, 8'hDE, 1'b0, "rom 8000");
        mem_read(16'h8001, 8'hAD, 1'b0, "rom 8001");
        mem_read(16'hFFFF, 8'h44, 1'b0, "rom ffff");
        mem_read(16'h8005, 8'h39, 1'b1, "extrom 8005");

        // Reply latch
        step(1'b1, 1'b0, 16'h7FFF, 8'h9C, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, "");
        check("reply wr valid", 32'(reply_valid0), 32'd1);
        check("reply wr data", 32'(mcpu_reply0), 32'h9C);
        step(1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, "");
        check("reply ack valid", 32'(reply_valid0), 32'd0);
        check("reply ack data", 32'(mcpu_reply0), 32'h9C);
        step(1'b1, 1'b0, 16'h6000, 8'h3D, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, "");
        check("reply wr+ack valid", 32'(reply_valid0), 32'd1);
        check("reply wr+ack data", 32'(mcpu_reply0), 32'h3D);
        check("reply wr no pop", 32'(fifo_count0), 32'd0);

        // NMI pulse retrigger on the IRQ_MODE=1 instance
        repeat (20) @(posedge clk_sys);
        #1;
        check("nmi idle", 32'(snd_irq1), 32'd0);
        high_cnt = 0;
        seen_low = 1'b0;
        regap    = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_sys);
            snd_write = (i == 0 || i == 5);
            mcpu_dout = 8'(8'h40 + i);
            @(posedge clk_sys);
            #1;
            snd_write = 1'b0;
            if (snd_irq1) begin
                high_cnt++;
                if (seen_low) regap = 1'b1;
            end else if (high_cnt > 0) begin
                seen_low = 1'b1;
            end
        end
        check("nmi width", 32'(high_cnt), 32'd21);
        check("nmi continuous", 32'(regap), 32'd0);
        check("nmi fifo count", 32'(fifo_count1), 32'd2);

        // Dropped push must not fire a pulse
        step(1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 8'h99, 1'b0, 1'b0, 8'h00, "");
        check("nmi dropped push", 32'(snd_irq1), 32'd0);
        check("nmi dropped count", 32'(fifo_count1), 32'd2);
        check("nmi dropped ovf", 32'(overflow1), 32'd1);
        check("scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
